serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq.sv | 166 ++++++++++++++++
 tb/tb_serial_add_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial adder/subtractor: one full adder, one bit per clock LSB first, WIDTH RUN cycles then a one-cycle DONE.
// Optional SERIAL_ADD_SEQ_ZERO_FLAG_EN adds a registered zero-result flag held alongside result.

module full_addr (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ c_i;
  assign cout_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADD_SEQ_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  full_addr u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .c_i    (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state; the counter holds on the last bit so it never wraps.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        if (last_bit) begin
          msb_cin_d = carry_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      cnt_q     <= cnt_d;
    end
  end

  // carry_q and msb_cin_q are untouched from DONE until the next accepted start.
  assign result   = res_q;
  assign cout     = carry_q;
  assign overflow = msb_cin_q ^ carry_q;

`ifdef SERIAL_ADD_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (state_q == RUN && last_bit) begin
      zero_d = ({fa_sum, res_q[WIDTH-1:1]} == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized and directed checks of serial_add_seq against an arithmetic reference model.
module tb_serial_add_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         cout, overflow, busy, done;
`ifdef SERIAL_ADD_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
`ifdef SERIAL_ADD_SEQ_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer add/subtract.
  function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic o);
    logic [W:0] wide;
    longint sx, sy, v, smax, smin;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    wide = {1'b0, x} + {1'b0, y};
    r    = s ? (x - y) : (x + y);
    c    = s ? (x >= y) : wide[W];
    v    = s ? (sx - sy) : (sx + sy);
    o    = (v > smax) || (v < smin);
  endfunction

  // Model: m_cnt = -1 idle, 0..W-1 busy cycles, W the done cycle.
  int           m_cnt = -1;
  logic [W-1:0] m_res = '0, p_res = '0;
  logic         m_c = 1'b0, m_o = 1'b0, m_z = 1'b0;
  logic         p_c = 1'b0, p_o = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = -1;
      m_res = '0;
      m_c   = 1'b0;
      m_o   = 1'b0;
      m_z   = 1'b0;
    end else if (m_cnt == -1) begin
      if (start) begin
        ref_op(a, b, sub, p_res, p_c, p_o);
        m_cnt = 0;
      end
    end else if (m_cnt == W) begin
      m_cnt = -1;
    end else begin
      m_cnt++;
      if (m_cnt == W) begin
        m_res = p_res;
        m_c   = p_c;
        m_o   = p_o;
        m_z   = (p_res == '0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_cnt >= 0 && m_cnt < W));
      chk("done", 64'(done), 64'(m_cnt == W));
      if (m_cnt == W || m_cnt == -1) begin
        chk("result", 64'(result), 64'(m_res));
        chk("cout", 64'(cout), 64'(m_c));
        chk("overflow", 64'(overflow), 64'(m_o));
`ifdef SERIAL_ADD_SEQ_ZERO_FLAG_EN
        chk("zero", 64'(zero), 64'(m_z));
`endif
      end
    end
  end

  task automatic wait_done(output int n, output int bcnt);
    n = 1;
    bcnt = 0;
    while (!done && n < 3 * W) begin
      if (busy) bcnt++;
      @(negedge clk);
      n++;
    end
  endtask

  // One operation from IDLE with literal expectations; operands scrambled right after the start sample.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts,
                       input logic [W-1:0] lr, input logic lc, input logic lo);
    int n, bcnt;
    logic [W-1:0] mr;
    logic mc, mo;
    ref_op(ta, tb2, ts, mr, mc, mo);
    chk("model_result", 64'(mr), 64'(lr));
    chk("model_ovf", 64'(mo), 64'(lo));
    @(negedge clk);
    a = ta; b = tb2; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
    wait_done(n, bcnt);
    chk("latency", 64'(n), 64'(W + 1));
    chk("busy_cycles", 64'(bcnt), 64'(W));
    chk("lit_result", 64'(result), 64'(lr));
    chk("lit_cout", 64'(cout), 64'(lc));
    chk("lit_ovf", 64'(overflow), 64'(lo));
`ifdef SERIAL_ADD_SEQ_ZERO_FLAG_EN
    chk("lit_zero", 64'(zero), 64'(lr == '0));
`endif
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'(0));
    chk("hold_result", 64'(result), 64'(lr));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n, bcnt;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    rst = 1'b0;

    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // start held high: one done pulse, then a second op from the operands present at re-accept
    @(negedge clk);
    a = 32'h10; b = 32'h20; sub = 1'b0; start = 1'b1;
    repeat (6) @(negedge clk);
    a = 32'h100; b = 32'h1;
    wait_done(n, bcnt);
    chk("held_result1", 64'(result), 64'(32'h30));
    @(negedge clk);
    chk("held_idle_done", 64'(done), 64'(0));
    chk("held_idle_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("held_restart", 64'(busy), 64'(1));
    start = 1'b0;
    wait_done(n, bcnt);
    chk("held_result2", 64'(result), 64'(32'h101));
    @(negedge clk);

    // asynchronous reset in the middle of RUN
    a = 32'hFFFF_FFFF; b = 32'h3; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_result", 64'(result), 64'(0));
    chk("arst_cout", 64'(cout), 64'(0));
    chk("arst_ovf", 64'(overflow), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    do_op(32'h2, 32'h2, 1'b0, 32'h4, 1'b0, 1'b0);

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = pick();
      b = pick();
      sub = 1'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
